// File: rtl/tt_sweep_checker.sv
// Sequential truth-table checker: sweeps every input vector of an external
// N_IN-input function, samples its output after SETTLE wait cycles, and
// compares the captured table bit-by-bit against an expected table.
// Each vector takes SETTLE+2 cycles, so a full sweep is 2^N_IN*(SETTLE+2)
// cycles from the first busy cycle to the first done cycle.
//
// Optional build macro: TT_SWEEP_STOP_ON_FAIL_EN ends the sweep at the
// first failing vector.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start           begin a sweep; honoured in IDLE and DONE only
//   expected        expected table, bit i = f(i); registered on accepted start
//   stim_out        registered input vector to the function under test
//   func_in         function output, sampled only in SAMPLE
//   busy, done      sweep in progress / results valid
//   captured        captured table, bit i = func_in sampled for stim_out = i
//   mismatch_cnt    number of differing indices (holds 2^N_IN)
//   first_mismatch  lowest failing index, valid when mismatch_flag is high
//   mismatch_flag   at least one mismatch in the current sweep
module tt_sweep_checker #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      stim_out,
  input  logic                 func_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   captured,
  output logic [N_IN:0]        mismatch_cnt,
  output logic [N_IN-1:0]      first_mismatch,
  output logic                 mismatch_flag
);

  localparam int W = 2**N_IN;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [N_IN-1:0] STIM_LAST = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] STIM_ONE  = N_IN'(1);
  localparam logic [N_IN:0]   CNT_ONE   = (N_IN+1)'(1);
  localparam logic [3:0]      WAIT_LOAD = 4'(SETTLE);

  logic [1:0]   state;
  logic [3:0]   wait_cnt;
  logic [W-1:0] expected_reg;

  // Mismatch on the vector being sampled this cycle.
  logic miss;
  assign miss = (func_in != expected_reg[stim_out]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      wait_cnt       <= '0;
      expected_reg   <= '0;
      stim_out       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      captured       <= '0;
      mismatch_cnt   <= '0;
      first_mismatch <= '0;
      mismatch_flag  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          // DONE holds results until a new start re-arms the engine.
          if (start) begin
            expected_reg   <= expected;
            captured       <= '0;
            mismatch_cnt   <= '0;
            mismatch_flag  <= 1'b0;
            first_mismatch <= '0;
            done           <= 1'b0;
            busy           <= 1'b1;
            stim_out       <= '0;
            wait_cnt       <= WAIT_LOAD;
            state          <= ST_DRIVE;
          end
        end

        ST_DRIVE: begin
          if (wait_cnt == 4'd0) begin
            state <= ST_SAMPLE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        ST_SAMPLE: begin
          captured[stim_out] <= func_in;
          if (miss) begin
            mismatch_cnt <= mismatch_cnt + CNT_ONE;
            if (!mismatch_flag) begin
              mismatch_flag  <= 1'b1;
              first_mismatch <= stim_out;
            end
          end
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
          // First failure ends the sweep; stim_out keeps the failing index.
          if ((miss && !mismatch_flag) || (stim_out == STIM_LAST)) begin
`else
          // Terminal index is detected before increment so stim_out never wraps.
          if (stim_out == STIM_LAST) begin
`endif
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            stim_out <= stim_out + STIM_ONE;
            wait_cnt <= WAIT_LOAD;
            state    <= ST_DRIVE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
